// File: rtl/ghost_move_scheduler_if.sv
// Handshake bundle between the ghost move scheduler and the shared collision checker.
// The scheduler is the master: it presents one ghost and waits for the checker verdict.
interface ghost_move_scheduler_if;
    logic       chk_req;
    logic [9:0] chk_x;
    logic [8:0] chk_y;
    logic [1:0] chk_dir;
    logic       chk_ack;
    logic       chk_blocked;

    modport master (
        output chk_req, chk_x, chk_y, chk_dir,
        input  chk_ack, chk_blocked
    );

    modport slave (
        input  chk_req, chk_x, chk_y, chk_dir,
        output chk_ack, chk_blocked
    );
endinterface

// File: rtl/ghost_move_scheduler.sv
// Sweeps all ghosts on each move tick through one shared collision checker,
// stepping free ghosts one pixel and re-rolling the direction of blocked ones.
module ghost_move_scheduler #(
    parameter int unsigned N_GHOSTS  = 4,
    parameter int unsigned X0        = 200,
    parameter int unsigned X_STEP    = 16,
    parameter int unsigned Y0        = 146,
    parameter int unsigned X_MAX     = 639,
    parameter int unsigned Y_MAX     = 479,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_move_tick,
    input  logic                    i_freeze,
    input  logic [N_GHOSTS-1:0]     i_ghost_en,
    ghost_move_scheduler_if.master  chk,
    output logic [10*N_GHOSTS-1:0]  o_ghost_x,
    output logic [9*N_GHOSTS-1:0]   o_ghost_y,
    output logic [2*N_GHOSTS-1:0]   o_ghost_dir,
    output logic                    o_busy,
    output logic                    o_sweep_done,
    output logic                    o_overrun
);
    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_WAIT, S_UPDATE, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_idx;
    logic [9:0]  r_x   [N_GHOSTS];
    logic [8:0]  r_y   [N_GHOSTS];
    logic [1:0]  r_dir [N_GHOSTS];
    logic        r_pending, r_overrun, r_blocked, r_chk_req;
    logic [15:0] r_lfsr;
    logic [9:0]  r_chk_x;
    logic [8:0]  r_chk_y;
    logic [1:0]  r_chk_dir;

    logic        w_tick, w_start, w_valid, w_en, w_edge;
    logic [9:0]  w_cur_x;
    logic [8:0]  w_cur_y;
    logic [1:0]  w_cur_dir, w_rnd_dir;

    assign w_tick  = i_move_tick & ~i_freeze;
    assign w_start = w_tick | r_pending;

    // Ghost under the sweep pointer; w_valid drops once idx runs past the last ghost.
    always_comb begin
        w_valid   = 1'b0;
        w_en      = 1'b0;
        w_cur_x   = '0;
        w_cur_y   = '0;
        w_cur_dir = '0;
        for (int unsigned i = 0; i < N_GHOSTS; i++) begin
            if (r_idx == 4'(i)) begin
                w_valid   = 1'b1;
                w_en      = i_ghost_en[i];
                w_cur_x   = r_x[i];
                w_cur_y   = r_y[i];
                w_cur_dir = r_dir[i];
            end
        end
    end

    assign w_edge = (w_cur_x == 10'd0          && w_cur_dir == 2'b10) ||
                    (w_cur_x == 10'(X_MAX)     && w_cur_dir == 2'b11) ||
                    (w_cur_y == 9'd0           && w_cur_dir == 2'b00) ||
                    (w_cur_y == 9'(Y_MAX)      && w_cur_dir == 2'b01);

    assign w_rnd_dir = (r_lfsr[1:0] == w_cur_dir) ? w_cur_dir + 2'd1 : r_lfsr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_SELECT;
            S_SELECT: begin
                if (!w_valid)    w_next = S_DONE;
                else if (!w_en)  w_next = S_SELECT;
                else if (w_edge) w_next = S_UPDATE;
                else             w_next = S_WAIT;
            end
            S_WAIT:   if (chk.chk_ack) w_next = S_UPDATE;
            S_UPDATE: w_next = S_SELECT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (r_state != S_IDLE);
        o_sweep_done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_blocked <= 1'b0;
            r_chk_req <= 1'b0;
            r_chk_x   <= '0;
            r_chk_y   <= '0;
            r_chk_dir <= '0;
            r_lfsr    <= LFSR_SEED;
            for (int unsigned i = 0; i < N_GHOSTS; i++) begin
                r_x[i]   <= 10'(X0 + i * X_STEP);
                r_y[i]   <= 9'(Y0);
                r_dir[i] <= 2'b00;
            end
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            if (w_tick && r_pending) r_overrun <= 1'b1;
            // A tick arriving mid-sweep (including DONE) is remembered once.
            if (r_state != S_IDLE && w_tick && !r_pending) r_pending <= 1'b1;
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_idx     <= '0;
                    r_pending <= 1'b0;
                end
                S_SELECT: if (w_valid) begin
                    if (!w_en)       r_idx     <= r_idx + 4'd1;
                    else if (w_edge) r_blocked <= 1'b1;
                    else begin
                        r_chk_x   <= w_cur_x;
                        r_chk_y   <= w_cur_y;
                        r_chk_dir <= w_cur_dir;
                        r_chk_req <= 1'b1;
                    end
                end
                S_WAIT: if (chk.chk_ack) begin
                    r_blocked <= chk.chk_blocked;
                    r_chk_req <= 1'b0;
                end
                S_UPDATE: begin
                    for (int unsigned i = 0; i < N_GHOSTS; i++) begin
                        if (r_idx == 4'(i)) begin
                            if (r_blocked) r_dir[i] <= w_rnd_dir;
                            else begin
                                case (r_dir[i])
                                    2'b00:   r_y[i] <= r_y[i] - 9'd1;
                                    2'b01:   r_y[i] <= r_y[i] + 9'd1;
                                    2'b10:   r_x[i] <= r_x[i] - 10'd1;
                                    default: r_x[i] <= r_x[i] + 10'd1;
                                endcase
                            end
                        end
                    end
                    r_idx <= r_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign chk.chk_req = r_chk_req;
    assign chk.chk_x   = r_chk_x;
    assign chk.chk_y   = r_chk_y;
    assign chk.chk_dir = r_chk_dir;
    assign o_overrun   = r_overrun;

    always_comb begin
        o_ghost_x   = '0;
        o_ghost_y   = '0;
        o_ghost_dir = '0;
        for (int unsigned i = 0; i < N_GHOSTS; i++) begin
            o_ghost_x[10*i +: 10] = r_x[i];
            o_ghost_y[9*i +: 9]   = r_y[i];
            o_ghost_dir[2*i +: 2] = r_dir[i];
        end
    end
endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Directed bench: a table of sweeps on a 4-ghost scheduler plus hand-written sequences
// for stalled acks, tick overrun, async reset mid-handshake and playfield-edge handling.
module tb_ghost_move_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0, tick2 = 1'b0, freeze = 1'b0;
    logic [3:0]  en = 4'b1111;
    logic [39:0] o_x;
    logic [35:0] o_y;
    logic [7:0]  o_dir;
    logic        o_busy, o_done, o_overrun;
    logic [9:0]  o2_x;
    logic [8:0]  o2_y;
    logic [1:0]  o2_dir;
    logic        o2_busy, o2_done, o2_overrun;

    ghost_move_scheduler_if ifc ();
    ghost_move_scheduler_if ifc2 ();

    always #5 clk = ~clk;

    ghost_move_scheduler dut (
        .clk(clk), .rst(rst), .i_move_tick(tick), .i_freeze(freeze), .i_ghost_en(en),
        .chk(ifc), .o_ghost_x(o_x), .o_ghost_y(o_y), .o_ghost_dir(o_dir),
        .o_busy(o_busy), .o_sweep_done(o_done), .o_overrun(o_overrun)
    );

    // Single ghost parked in the corner (0,0) with X_MAX=0: up, left and right are all edges.
    ghost_move_scheduler #(.N_GHOSTS(1), .X0(0), .X_STEP(16), .Y0(0), .X_MAX(0), .Y_MAX(479)) dut2 (
        .clk(clk), .rst(rst), .i_move_tick(tick2), .i_freeze(freeze), .i_ghost_en(1'b1),
        .chk(ifc2), .o_ghost_x(o2_x), .o_ghost_y(o2_y), .o_ghost_dir(o2_dir),
        .o_busy(o2_busy), .o_sweep_done(o2_done), .o_overrun(o2_overrun)
    );

    int n_vec = 0, n_err = 0;
    int ack_delay = 0, hs1 = 0, hs2 = 0, stable_err = 0;
    logic [3:0] blk_mask = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Checker model for dut: ghost identified by its (never-changing) x column.
    initial begin
        int wcnt, g;
        logic [20:0] cap;
        ifc.chk_ack = 1'b0; ifc.chk_blocked = 1'b0; wcnt = 0; cap = '0;
        forever begin
            @(negedge clk);
            ifc.chk_ack = 1'b0; ifc.chk_blocked = 1'b0;
            if (rst || !ifc.chk_req) wcnt = 0;
            else begin
                if (wcnt == 0) cap = {ifc.chk_x, ifc.chk_y, ifc.chk_dir};
                else if ({ifc.chk_x, ifc.chk_y, ifc.chk_dir} != cap) stable_err++;
                if (wcnt >= ack_delay) begin
                    g = (int'(ifc.chk_x) - 200) / 16;
                    ifc.chk_ack = 1'b1;
                    ifc.chk_blocked = (g >= 0 && g < 4) ? blk_mask[g] : 1'b0;
                    hs1++;
                    wcnt = 0;
                end else wcnt++;
            end
        end
    end

    // Checker model for dut2: every request is answered at once as blocked.
    initial begin
        ifc2.chk_ack = 1'b0; ifc2.chk_blocked = 1'b0;
        forever begin
            @(negedge clk);
            ifc2.chk_ack = 1'b0; ifc2.chk_blocked = 1'b0;
            if (!rst && ifc2.chk_req) begin
                ifc2.chk_ack = 1'b1; ifc2.chk_blocked = 1'b1; hs2++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_sweep(input bit sel, input string name, output int cyc);
        bit seen;
        seen = 1'b0; cyc = 0;
        @(negedge clk);
        if (sel) tick2 = 1'b1; else tick = 1'b1;
        while (!seen && cyc < 400) begin
            @(negedge clk); cyc++;
            if (cyc == 1) begin
                tick = 1'b0; tick2 = 1'b0;
                if (!sel) check({name, " busy"}, 64'(o_busy), 64'd1);
            end
            seen = sel ? o2_done : o_done;
        end
        check({name, " done"}, 64'(seen), 64'd1);
    endtask

    typedef struct {
        bit          do_rst;
        bit          do_sweep;
        logic [3:0]  en;
        logic [3:0]  blk;
        int          exp_hs;
        int          exp_cyc;
        logic [39:0] exp_x;
        logic [35:0] exp_y;
        logic [3:0]  dir_eq;
        logic [3:0]  dir_ne;
    } vec_t;

    localparam logic [39:0] XR = {10'd248, 10'd232, 10'd216, 10'd200};
    localparam logic [35:0] YR = {9'd146, 9'd146, 9'd146, 9'd146};

    initial begin
        vec_t tbl[7];
        int cyc, hb, dones, seen_left;
        logic [1:0] old;
        string nm;

        tbl[0] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 0, 0,  XR, YR, 4'b1111, 4'b0000};
        tbl[1] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4, 14, XR,
                   {9'd145, 9'd145, 9'd145, 9'd145}, 4'b1111, 4'b0000};
        tbl[2] = '{1'b0, 1'b1, 4'b0101, 4'b0000, 2, 10, XR,
                   {9'd145, 9'd144, 9'd145, 9'd144}, 4'b1111, 4'b0000};
        tbl[3] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 0, 6,  XR,
                   {9'd145, 9'd144, 9'd145, 9'd144}, 4'b1111, 4'b0000};
        tbl[4] = '{1'b0, 1'b1, 4'b1000, 4'b0000, 1, 8,  XR,
                   {9'd144, 9'd144, 9'd145, 9'd144}, 4'b1111, 4'b0000};
        tbl[5] = '{1'b1, 1'b1, 4'b1111, 4'b0010, 4, 14, XR,
                   {9'd145, 9'd145, 9'd146, 9'd145}, 4'b1101, 4'b0010};
        tbl[6] = '{1'b0, 1'b1, 4'b1101, 4'b0000, 3, 12, XR,
                   {9'd144, 9'd144, 9'd146, 9'd144}, 4'b1101, 4'b0010};

        for (int v = 0; v < 7; v++) begin
            nm = $sformatf("v%0d", v);
            if (tbl[v].do_rst) begin
                do_reset();
                check({nm, " rst req"},     64'(ifc.chk_req), 64'd0);
                check({nm, " rst busy"},    64'(o_busy), 64'd0);
                check({nm, " rst overrun"}, 64'(o_overrun), 64'd0);
                check({nm, " rst done"},    64'(o_done), 64'd0);
            end
            if (tbl[v].do_sweep) begin
                en = tbl[v].en; blk_mask = tbl[v].blk; hb = hs1;
                run_sweep(1'b0, nm, cyc);
                check({nm, " handshakes"}, 64'(hs1 - hb), 64'(tbl[v].exp_hs));
                check({nm, " cycles"}, 64'(cyc), 64'(tbl[v].exp_cyc));
            end
            check({nm, " x"}, 64'(o_x), 64'(tbl[v].exp_x));
            check({nm, " y"}, 64'(o_y), 64'(tbl[v].exp_y));
            for (int i = 0; i < 4; i++) begin
                if (tbl[v].dir_eq[i]) check($sformatf("%s dir%0d", nm, i), 64'(o_dir[2*i +: 2]), 64'd0);
                if (tbl[v].dir_ne[i]) check($sformatf("%s dir%0d changed", nm, i), 64'(o_dir[2*i +: 2] != 2'b00), 64'd1);
            end
        end

        // Async reset while ghost 0 waits on a stalled checker.
        en = 4'b1111; blk_mask = '0; ack_delay = 1000;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        cyc = 0;
        while (!ifc.chk_req && cyc < 20) begin @(negedge clk); cyc++; end
        check("rst_wait req seen", 64'(ifc.chk_req), 64'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_wait req", 64'(ifc.chk_req), 64'd0);
        check("rst_wait busy", 64'(o_busy), 64'd0);
        check("rst_wait x", 64'(o_x), 64'(XR));
        check("rst_wait y", 64'(o_y), 64'(YR));
        check("rst_wait dir", 64'(o_dir), 64'd0);
        @(negedge clk); rst = 1'b0; ack_delay = 0;
        hb = hs1;
        run_sweep(1'b0, "post_rst", cyc);
        check("post_rst handshakes", 64'(hs1 - hb), 64'd4);
        check("post_rst y", 64'(o_y), 64'({9'd145, 9'd145, 9'd145, 9'd145}));

        // Freeze, then slow acks with three ticks landing mid-sweep.
        do_reset();
        en = 4'b0001; ack_delay = 20; stable_err = 0;
        freeze = 1'b1;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (4) @(negedge clk);
        check("freeze busy", 64'(o_busy), 64'd0);
        freeze = 1'b0;
        hb = hs1; dones = 0;
        @(negedge clk); tick = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            tick = (c == 6 || c == 11 || c == 16) ? 1'b1 : 1'b0;
            if (o_done) dones++;
        end
        check("overrun sweeps", 64'(dones), 64'd2);
        check("overrun handshakes", 64'(hs1 - hb), 64'd2);
        check("overrun flag", 64'(o_overrun), 64'd1);
        check("overrun stable", 64'(stable_err), 64'd0);
        check("overrun y0", 64'(o_y[8:0]), 64'd144);
        check("overrun idle", 64'(o_busy), 64'd0);
        ack_delay = 0;

        // Corner ghost: edges skip the checker, checker path always blocked.
        seen_left = 0;
        for (int s = 0; s < 32; s++) begin
            old = o2_dir; hb = hs2;
            run_sweep(1'b1, $sformatf("edge%0d", s), cyc);
            check($sformatf("edge%0d req", s), 64'(hs2 - hb), (old == 2'b01) ? 64'd1 : 64'd0);
            check($sformatf("edge%0d pos", s), 64'({o2_x, o2_y}), 64'd0);
            check($sformatf("edge%0d dir", s), 64'(o2_dir != old), 64'd1);
            if (old == 2'b10) seen_left++;
        end
        check("edge left seen", 64'(seen_left > 0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
